// File: rtl/fifo_pkg.sv
// Shared types for the synchronous FIFO and its read-side drain stage.
package fifo_pkg;

   localparam int DATA_WIDTH = 16;

   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } occ_state_e;

endpackage

// File: rtl/drain_buf.sv
// Small circular output buffer: register array with wrapping write/read pointers
// and an occupancy count. The head entry is always visible on rd_data.
module drain_buf #(
   parameter int DATA_WIDTH = 16,
   parameter int BUF_DEPTH  = 2,
   localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [OCC_W-1:0]      occ
);

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      occ_d    = occ_q;
      if (wr_en && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (!wr_en && pop) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign occ     = occ_q;

endmodule

// File: rtl/fifo_stream_drain_sva.sv
// Protocol checks for the drain stage: no reads of an empty FIFO, bounded
// occupancy, and a stable output word while the sink stalls.
module fifo_stream_drain_sva
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int BUF_DEPTH  = 2,
   parameter int OCC_W      = 2
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  fifo_rd_en,
   input logic                  fifo_empty,
   input logic                  capture,
   input logic                  m_valid,
   input logic                  m_ready,
   input logic [DATA_WIDTH-1:0] m_data,
   input logic [OCC_W-1:0]      occ
);

   occ_state_e occ_state;

   always_comb begin
      occ_state = PARTIAL;
      if (occ == '0) begin
         occ_state = EMPTY;
      end else if (occ == OCC_W'(BUF_DEPTH)) begin
         occ_state = FULL;
      end
   end

   a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
      !(fifo_rd_en && fifo_empty));

   a_occ_bounded: assert property (@(posedge clk) disable iff (rst)
      occ <= OCC_W'(BUF_DEPTH));

   a_data_stable: assert property (@(posedge clk) disable iff (rst)
      (m_valid && !m_ready) |=> $stable(m_data));

   a_valid_matches_state: assert property (@(posedge clk) disable iff (rst)
      m_valid == (occ_state != EMPTY));

   // The credit check must guarantee room for every word already in flight.
   a_no_capture_when_full: assert property (@(posedge clk) disable iff (rst)
      !(capture && occ_state == FULL));

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side drain for the synchronous FIFO: credit-managed reads absorb the
// one-cycle read latency and the buffered words are presented as valid/ready.
module fifo_stream_drain
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int BUF_DEPTH  = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  words_out,
   output logic                  underflow_err
);

   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   logic                 inflight_q, inflight_d;
   logic                 underflow_err_q, underflow_err_d;
   logic [CNT_WIDTH-1:0] words_q, words_d;
   logic [OCC_W-1:0]     occ;
   logic [OCC_W:0]       committed;
   logic                 credit_ok;
   logic                 pop;
   logic                 capture;

   drain_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (capture),
      .wr_data (fifo_data_out),
      .pop     (pop),
      .rd_data (m_data),
      .occ     (occ)
   );

   assign m_valid = (occ != '0);
   assign pop     = m_valid && m_ready;
   assign capture = inflight_q && !fifo_underflow;

   // occ + inflight - pop < BUF_DEPTH, rearranged so nothing goes negative.
   assign committed  = {1'b0, occ} + (OCC_W + 1)'(inflight_q);
   assign credit_ok  = committed < ((OCC_W + 1)'(BUF_DEPTH) + (OCC_W + 1)'(pop));
   assign fifo_rd_en = enable && !fifo_empty && !rst && credit_ok;

   always_comb begin
      inflight_d      = fifo_rd_en;
      underflow_err_d = underflow_err_q || (inflight_q && fifo_underflow);
      words_d         = pop ? words_q + 1'b1 : words_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q      <= 1'b0;
         underflow_err_q <= 1'b0;
         words_q         <= '0;
      end else begin
         inflight_q      <= inflight_d;
         underflow_err_q <= underflow_err_d;
         words_q         <= words_d;
      end
   end

   assign words_out     = words_q;
   assign underflow_err = underflow_err_q;

   fifo_stream_drain_sva #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH),
      .OCC_W      (OCC_W)
   ) u_sva (
      .clk        (clk),
      .rst        (rst),
      .fifo_rd_en (fifo_rd_en),
      .fifo_empty (fifo_empty),
      .capture    (capture),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .occ        (occ)
   );

endmodule
